// File: rtl/acti_pkg.sv
// Shared types and default sizing for the activation pipe.
//   acti_mode_e : activation function selector (BYPASS, RELU, CLIP, LEAKY)
//   ACTI_*      : default parameter values for the stream and counters
package acti_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        RELU   = 2'd1,
        CLIP   = 2'd2,
        LEAKY  = 2'd3
    } acti_mode_e;

    localparam int ACTI_AXI_DATA_WIDTH = 128;
    localparam int ACTI_ELEM_WIDTH     = 8;
    localparam int ACTI_CNT_WIDTH      = 32;

endpackage

// File: rtl/acti_if.sv
// AXI-Stream bundle used for both the input and output side of acti_pipe.
//   tvalid/tdata/tkeep/tlast : driven by master
//   tready                   : driven by slave
interface acti_if
    import acti_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = ACTI_AXI_DATA_WIDTH
) ();
    localparam int KEEP_WIDTH = AXI_DATA_WIDTH / 8;

    logic                      tvalid;
    logic                      tready;
    logic [AXI_DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0]     tkeep;
    logic                      tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/acti_lane.sv
// Combinational activation for a single signed element.
//   x_i     : element, two's complement
//   keep_i  : byte enables covering this element; all zero forces output 0
//   mode_i  : activation function
//   clip_i  : unsigned upper bound for CLIP
//   shift_i : arithmetic right shift applied to negatives in LEAKY
//   y_o     : result
module acti_lane
    import acti_pkg::*;
#(
    parameter int ELEM_WIDTH = ACTI_ELEM_WIDTH
) (
    input  logic [ELEM_WIDTH-1:0]   x_i,
    input  logic [ELEM_WIDTH/8-1:0] keep_i,
    input  acti_mode_e              mode_i,
    input  logic [ELEM_WIDTH-1:0]   clip_i,
    input  logic [2:0]              shift_i,
    output logic [ELEM_WIDTH-1:0]   y_o
);
    logic signed [ELEM_WIDTH-1:0] x_s;
    logic signed [ELEM_WIDTH-1:0] shr;
    logic                         neg;

    assign x_s = $signed(x_i);
    // >>> on a signed operand sign-extends, which rounds toward -inf
    assign shr = x_s >>> shift_i;
    assign neg = x_i[ELEM_WIDTH-1];

    always_comb begin
        y_o = '0;
        if (|keep_i) begin
            case (mode_i)
                BYPASS: y_o = x_i;
                RELU:   y_o = neg ? '0 : x_i;
                // x is known non-negative past the first test, so an
                // unsigned compare against clip is exact
                CLIP:   y_o = neg ? '0 : ((x_i > clip_i) ? clip_i : x_i);
                LEAKY:  y_o = neg ? shr : x_i;
                default: y_o = x_i;
            endcase
        end
    end
endmodule

// File: rtl/acti_pipe.sv
// Per-element activation on an AXI-Stream, one beat per cycle, 1-cycle latency.
//   clk, rst_n     : clock, synchronous active-low reset
//   s_axis         : input stream (slave side)
//   m_axis         : output stream (master side), driven from a 2-entry FIFO head
//   cfg_mode/clip/shift : activation config, sampled on the first beat of a packet
//   busy           : data buffered or a packet still open
//   stat_pkt_cnt   : accepted tlast beats (wrapping)
//   stat_beat_cnt  : accepted beats (wrapping)
module acti_pipe
    import acti_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = ACTI_AXI_DATA_WIDTH,
    parameter int ELEM_WIDTH     = ACTI_ELEM_WIDTH,
    parameter int CNT_WIDTH      = ACTI_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    acti_if.slave                 s_axis,
    acti_if.master                m_axis,
    input  logic [1:0]            cfg_mode,
    input  logic [ELEM_WIDTH-1:0] cfg_clip,
    input  logic [2:0]            cfg_shift,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  stat_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  stat_beat_cnt
);
    localparam int NUM_LANES  = AXI_DATA_WIDTH / ELEM_WIDTH;
    localparam int KEEP_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int LANE_KEEP  = ELEM_WIDTH / 8;

    // packet / config state
    logic                  in_pkt_q, in_pkt_d;
    acti_mode_e            mode_q, mode_d;
    logic [ELEM_WIDTH-1:0] clip_q, clip_d;
    logic [2:0]            shift_q, shift_d;

    // 2-entry FIFO
    logic [1:0][AXI_DATA_WIDTH-1:0] dat_q, dat_d;
    logic [1:0][KEEP_WIDTH-1:0]     kp_q, kp_d;
    logic [1:0]                     lst_q, lst_d;
    logic                           wr_q, wr_d;
    logic                           rd_q, rd_d;
    logic [1:0]                     cnt_q, cnt_d;

    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

    logic                  push, pop;
    acti_mode_e            eff_mode;
    logic [ELEM_WIDTH-1:0] eff_clip;
    logic [2:0]            eff_shift;
    logic [NUM_LANES-1:0][ELEM_WIDTH-1:0] res;

    // Ready depends on occupancy only, so no combinational path from m_axis.tready
    assign s_axis.tready = (cnt_q != 2'd2);
    assign m_axis.tvalid = (cnt_q != 2'd0);
    assign m_axis.tdata  = dat_q[rd_q];
    assign m_axis.tkeep  = kp_q[rd_q];
    assign m_axis.tlast  = lst_q[rd_q];

    assign push = s_axis.tvalid & s_axis.tready;
    assign pop  = m_axis.tvalid & m_axis.tready;

    // The first beat of a packet uses the live cfg (the value being captured);
    // later beats use the held copy.
    assign eff_mode  = in_pkt_q ? mode_q  : acti_mode_e'(cfg_mode);
    assign eff_clip  = in_pkt_q ? clip_q  : cfg_clip;
    assign eff_shift = in_pkt_q ? shift_q : cfg_shift;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        acti_lane #(.ELEM_WIDTH(ELEM_WIDTH)) u_lane (
            .x_i     (s_axis.tdata[i*ELEM_WIDTH +: ELEM_WIDTH]),
            .keep_i  (s_axis.tkeep[i*LANE_KEEP +: LANE_KEEP]),
            .mode_i  (eff_mode),
            .clip_i  (eff_clip),
            .shift_i (eff_shift),
            .y_o     (res[i])
        );
    end

    always_comb begin
        in_pkt_d   = in_pkt_q;
        mode_d     = mode_q;
        clip_d     = clip_q;
        shift_d    = shift_q;
        dat_d      = dat_q;
        kp_d       = kp_q;
        lst_d      = lst_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        pkt_cnt_d  = pkt_cnt_q;
        beat_cnt_d = beat_cnt_q;

        if (push) begin
            if (!in_pkt_q) begin
                mode_d  = acti_mode_e'(cfg_mode);
                clip_d  = cfg_clip;
                shift_d = cfg_shift;
            end
            in_pkt_d    = ~s_axis.tlast;
            dat_d[wr_q] = res;
            kp_d[wr_q]  = s_axis.tkeep;
            lst_d[wr_q] = s_axis.tlast;
            wr_d        = ~wr_q;
            beat_cnt_d  = beat_cnt_q + CNT_WIDTH'(1);
            if (s_axis.tlast) pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
        end
        if (pop) rd_d = ~rd_q;
        cnt_d = cnt_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_pkt_q   <= 1'b0;
            mode_q     <= BYPASS;
            clip_q     <= '0;
            shift_q    <= '0;
            dat_q      <= '0;
            kp_q       <= '0;
            lst_q      <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            cnt_q      <= '0;
            pkt_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            in_pkt_q   <= in_pkt_d;
            mode_q     <= mode_d;
            clip_q     <= clip_d;
            shift_q    <= shift_d;
            dat_q      <= dat_d;
            kp_q       <= kp_d;
            lst_q      <= lst_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign busy          = (cnt_q != 2'd0) | in_pkt_q;
    assign stat_pkt_cnt  = pkt_cnt_q;
    assign stat_beat_cnt = beat_cnt_q;
endmodule

// File: doc/acti_pipe.md
ACTI_PIPE -- requirements
Module: acti_pipe

Interface
REQ-001 Parameter AXI_DATA_WIDTH, default 128, AXI-Stream data width in bits; SHALL be a multiple of ELEM_WIDTH.
REQ-002 Parameter ELEM_WIDTH, default 8, signed element width in bits (8 or 16 supported).
REQ-003 Parameter CNT_WIDTH, default 32, width of the statistics counters.
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 s_axis_tready/tvalid/tdata/tkeep/tlast  out/in/in/in/in  1/1/AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1  input stream.
REQ-007 m_axis_tready/tvalid/tdata/tkeep/tlast  in/out/out/out/out  same widths  output stream.
REQ-008 cfg_mode  in  2  activation: 0 bypass, 1 ReLU, 2 clipped ReLU, 3 leaky shift.
REQ-009 cfg_clip  in  ELEM_WIDTH  upper bound for mode 2; unsigned, non-negative.
REQ-010 cfg_shift  in  3  arithmetic right-shift amount for mode 3 negatives.
REQ-011 busy  out  1  high while any beat is buffered or a packet is open.
REQ-012 stat_pkt_cnt / stat_beat_cnt  out  CNT_WIDTH each  accepted packets / beats, wrapping.

Function
REQ-013 Each ELEM_WIDTH lane SHALL be processed independently, lane i = tdata[(i+1)*ELEM_WIDTH-1 : i*ELEM_WIDTH].
REQ-014 Mode 0 SHALL pass x; mode 1 SHALL output max(x,0); mode 2 SHALL output min(max(x,0),cfg_clip); mode 3 SHALL output x for x>=0, else x>>>cfg_shift (sign-extended, floor).
REQ-015 A lane whose tkeep bytes are all 0 SHALL output 0; tkeep and tlast SHALL be forwarded unchanged with their beat.
REQ-016 Active configuration SHALL be captured from cfg_* only when the first beat of a packet is accepted and held constant until that packet's tlast beat is accepted.
REQ-017 An in_pkt flag SHALL set on acceptance of a non-last beat and clear on acceptance of a tlast beat; a single-beat packet leaves it clear.
REQ-018 Results SHALL enter a 2-entry output FIFO; the FIFO head drives m_axis_*.
REQ-019 s_axis_tready SHALL be a function of FIFO occupancy only (high when count<2), never combinationally of m_axis_tready.
REQ-020 Latency SHALL be 1 cycle: beat accepted in cycle N is presented on m_axis in cycle N+1 when the FIFO was empty.
REQ-021 With m_axis_tready held high, throughput SHALL be one beat per cycle with no bubbles.
REQ-022 Simultaneous push and pop SHALL keep count unchanged; m_axis_tvalid/tdata SHALL stay stable while tvalid high and tready low.
REQ-023 stat_beat_cnt SHALL increment per accepted input beat; stat_pkt_cnt per accepted tlast beat; both wrap to 0 from all-ones.
REQ-024 busy SHALL equal (count!=0) | in_pkt.

Reset
REQ-025 On rst_n low at a clock edge: FIFO empty, m_axis_tvalid/tdata/tkeep/tlast=0, in_pkt=0, active mode=0, clip=0, shift=0, both counters=0.
REQ-026 Reset mid-packet SHALL discard buffered beats; s_axis_tready SHALL be high in the first cycle after reset release.

Structure
REQ-027 Package acti_pkg SHALL hold the acti_mode_e enum (BYPASS, RELU, CLIP, LEAKY) and the default parameter constants.
REQ-028 Sub-module acti_lane SHALL implement REQ-014/015 for one element, combinationally; acti_pipe instantiates AXI_DATA_WIDTH/ELEM_WIDTH copies.

Verification
REQ-029 Mode 1, ELEM_WIDTH 8, beat lanes {0x85,0x7F,0x00,0xFF}, tready high -> output {0x00,0x7F,0x00,0x00} one cycle later.
REQ-030 Mode 2, clip 0x20, lanes {0x10,0x40,0x80} -> {0x10,0x20,0x00}; mode 3, shift 2, lane 0xF3 (-13) -> 0xFC (-4).
REQ-031 cfg_mode changed 1->0 during a 4-beat packet -> all 4 beats ReLU-processed; next packet bypassed.
REQ-032 m_axis_tready low for 5 cycles with continuous input -> exactly 2 beats buffered, s_axis_tready low, no data loss or reorder; data stable.
REQ-033 1000 random beats, random tvalid/tready, packets of 1-7 beats -> scoreboard match, stat_beat_cnt=1000, stat_pkt_cnt equals tlast count.
REQ-034 rst_n asserted with 2 beats buffered -> m_axis_tvalid 0, busy 0, counters 0 next cycle.
